// File: rtl/beta_pkg.sv
// Shared CPU definitions for the beta pipeline: hazard controller states
// and the hard-wired zero register.
package beta_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_R31 = 5'd31;

endpackage

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: load-use stalls, branch annul and memory-wait freeze with timeout.
// Optional perf counters (ld_stall_cnt, mem_wait_cnt) are built when HAZARD_PERF_CNT_EN is defined.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal flow; a pending data access without ack freezes here
// MEM_WAIT | data access still pending; counts cycles towards timeout
// ERROR    | memory never acknowledged; frozen until reset
module hazard_ctl
    import beta_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra_rf,
    input  logic [4:0]  rb_rf,
    input  logic        ra_used_rf,
    input  logic        rb_used_rf,
    input  logic [4:0]  rc_ex,
    input  logic        op_ld_ex,
    input  logic [4:0]  rc_mem,
    input  logic        op_ld_mem,
    input  logic        br_taken_rf,
    input  logic        mem_op_mem,
    input  logic        dmem_ack,
    output logic        stall_if,
    output logic        stall_rf,
    output logic        bubble_ex,
    output logic        annul_if,
    output logic        freeze,
    output logic        mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] ld_stall_cnt,
    output logic [31:0] mem_wait_cnt
`endif
);

    localparam logic [8:0] TIMEOUT_W = 9'(MEM_TIMEOUT);

    hz_state_e  state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [8:0] wait_inc;
    logic       ra_hz, rb_hz, ld_hazard;
    logic       freeze_c, err_c, stall_c;

    // R31 reads as zero, so a load targeting it never creates a dependency.
    assign ra_hz = ra_used_rf && (ra_rf != REG_R31) &&
                   ((op_ld_ex && (ra_rf == rc_ex)) || (op_ld_mem && (ra_rf == rc_mem)));
    assign rb_hz = rb_used_rf && (rb_rf != REG_R31) &&
                   ((op_ld_ex && (rb_rf == rc_ex)) || (op_ld_mem && (rb_rf == rc_mem)));
    assign ld_hazard = ra_hz || rb_hz;

    assign wait_inc = {1'b0, wait_cnt_q} + 9'd1;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze_c   = 1'b0;
        err_c      = 1'b0;
        case (state_q)
            ST_RUN: begin
                freeze_c = mem_op_mem && !dmem_ack;
                if (freeze_c) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            ST_MEM_WAIT: begin
                freeze_c = !dmem_ack;
                if (dmem_ack) begin
                    state_d = ST_RUN;
                end else begin
                    wait_cnt_d = wait_inc[7:0];
                    if (wait_inc >= TIMEOUT_W) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                freeze_c = 1'b1;
                err_c    = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Freeze wins over everything; a load stall hides the branch because its operands are stale.
    assign stall_c         = !rst && !freeze_c && ld_hazard;
    assign stall_if        = stall_c;
    assign stall_rf        = stall_c;
    assign bubble_ex       = stall_c;
    assign annul_if        = !rst && !freeze_c && !ld_hazard && br_taken_rf;
    assign freeze          = !rst && freeze_c;
    assign mem_timeout_err = !rst && err_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] ld_stall_cnt_q, mem_wait_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_stall_cnt_q <= 32'd0;
            mem_wait_cnt_q <= 32'd0;
        end else begin
            if (stall_rf) begin
                ld_stall_cnt_q <= ld_stall_cnt_q + 32'd1;
            end
            if (freeze && (state_q != ST_ERROR)) begin
                mem_wait_cnt_q <= mem_wait_cnt_q + 32'd1;
            end
        end
    end

    assign ld_stall_cnt = rst ? 32'd0 : ld_stall_cnt_q;
    assign mem_wait_cnt = rst ? 32'd0 : mem_wait_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Scoreboard bench for hazard_ctl (MEM_TIMEOUT=4); perf counters checked when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctl;

    typedef struct packed {
        logic       r;
        logic [4:0] ra;
        logic       rau;
        logic [4:0] rb;
        logic       rbu;
        logic [4:0] rce;
        logic       lde;
        logic [4:0] rcm;
        logic       ldm;
        logic       br;
        logic       mo;
        logic       ack;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] ra_rf, rb_rf, rc_ex, rc_mem;
    logic ra_used_rf, rb_used_rf, op_ld_ex, op_ld_mem, br_taken_rf, mem_op_mem, dmem_ack;
    logic stall_if, stall_rf, bubble_ex, annul_if, freeze, mem_timeout_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] ld_stall_cnt, mem_wait_cnt;
`endif

    int checks = 0;
    int passed = 0;
    // expected {stall_if, stall_rf, bubble_ex, annul_if, freeze, mem_timeout_err}
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    hazard_ctl #(.MEM_TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .ra_rf          (ra_rf),
        .rb_rf          (rb_rf),
        .ra_used_rf     (ra_used_rf),
        .rb_used_rf     (rb_used_rf),
        .rc_ex          (rc_ex),
        .op_ld_ex       (op_ld_ex),
        .rc_mem         (rc_mem),
        .op_ld_mem      (op_ld_mem),
        .br_taken_rf    (br_taken_rf),
        .mem_op_mem     (mem_op_mem),
        .dmem_ack       (dmem_ack),
        .stall_if       (stall_if),
        .stall_rf       (stall_rf),
        .bubble_ex      (bubble_ex),
        .annul_if       (annul_if),
        .freeze         (freeze),
        .mem_timeout_err(mem_timeout_err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .ld_stall_cnt   (ld_stall_cnt),
        .mem_wait_cnt   (mem_wait_cnt)
`endif
    );

    function automatic stim_t mk(logic r, logic [4:0] ra, logic rau, logic [4:0] rb, logic rbu,
                                 logic [4:0] rce, logic lde, logic [4:0] rcm, logic ldm,
                                 logic br, logic mo, logic ack);
        stim_t s;
        s.r = r; s.ra = ra; s.rau = rau; s.rb = rb; s.rbu = rbu;
        s.rce = rce; s.lde = lde; s.rcm = rcm; s.ldm = ldm;
        s.br = br; s.mo = mo; s.ack = ack;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rst = s.r; ra_rf = s.ra; ra_used_rf = s.rau; rb_rf = s.rb; rb_used_rf = s.rbu;
        rc_ex = s.rce; op_ld_ex = s.lde; rc_mem = s.rcm; op_ld_mem = s.ldm;
        br_taken_rf = s.br; mem_op_mem = s.mo; dmem_ack = s.ack;
    endtask

    function automatic logic [5:0] outs();
        return {stall_if, stall_rf, bubble_ex, annul_if, freeze, mem_timeout_err};
    endfunction

    task automatic test_reset();
        stim_t s[$]; logic [5:0] e[$]; logic [5:0] got, ex;
        s.push_back(mk(1, 1,1, 0,0, 1,1, 0,0, 1, 1,0)); e.push_back(6'b000000);
        s.push_back(mk(1, 1,1, 0,0, 1,1, 0,0, 1, 1,0)); e.push_back(6'b000000);
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0, 0,0)); e.push_back(6'b000000);
        for (int i = 0; i < s.size(); i++) begin
            @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
            @(negedge clk); got = outs(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) $display("FAIL reset[%0d] got=%b exp=%b", i, got, ex); else passed++;
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (ld_stall_cnt !== 32'd0 || mem_wait_cnt !== 32'd0)
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", ld_stall_cnt, mem_wait_cnt);
        else passed++;
`endif
    endtask

    task automatic test_ld_ex();
        stim_t s[$]; logic [5:0] e[$]; logic [5:0] got, ex;
        s.push_back(mk(0, 1,1, 4,1, 1,1, 9,0, 0, 0,0)); e.push_back(6'b111000);
        s.push_back(mk(0, 1,1, 4,1, 0,0, 1,1, 0, 0,0)); e.push_back(6'b111000);
        s.push_back(mk(0, 1,1, 4,1, 0,0, 0,0, 0, 0,0)); e.push_back(6'b000000);
        for (int i = 0; i < s.size(); i++) begin
            @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
            @(negedge clk); got = outs(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) $display("FAIL ld_ex[%0d] got=%b exp=%b", i, got, ex); else passed++;
        end
    endtask

    task automatic test_mem_wait();
        stim_t s[$]; logic [5:0] e[$]; logic [5:0] got, ex;
        for (int k = 0; k < 3; k++) begin
            s.push_back(mk(0, 1,1, 0,0, 1,1, 0,0, 1, 1,0)); e.push_back(6'b000010);
        end
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0, 1,1)); e.push_back(6'b000000);
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0, 0,0)); e.push_back(6'b000000);
        for (int i = 0; i < s.size(); i++) begin
            @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
            @(negedge clk); got = outs(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) $display("FAIL mem_wait[%0d] got=%b exp=%b", i, got, ex); else passed++;
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (ld_stall_cnt !== 32'd2 || mem_wait_cnt !== 32'd3)
            $display("FAIL perf_cnt got=%0d/%0d exp=2/3", ld_stall_cnt, mem_wait_cnt);
        else passed++;
`endif
    endtask

    task automatic test_no_stall();
        stim_t s[$]; logic [5:0] e[$]; logic [5:0] got, ex;
        s.push_back(mk(0, 31,1, 31,1, 31,1, 0,0, 0, 0,0)); e.push_back(6'b000000);
        s.push_back(mk(0, 31,1, 31,1, 0,0, 31,1, 1, 0,0)); e.push_back(6'b000100);
        s.push_back(mk(0, 3,0, 7,1, 3,1, 7,1, 0, 0,0));    e.push_back(6'b111000);
        s.push_back(mk(0, 3,0, 7,1, 0,0, 0,0, 0, 0,0));    e.push_back(6'b000000);
        s.push_back(mk(0, 6,1, 8,1, 5,1, 9,1, 0, 0,0));    e.push_back(6'b000000);
        s.push_back(mk(0, 6,1, 8,1, 8,0, 6,0, 0, 0,0));    e.push_back(6'b000000);
        for (int i = 0; i < s.size(); i++) begin
            @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
            @(negedge clk); got = outs(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) $display("FAIL no_stall[%0d] got=%b exp=%b", i, got, ex); else passed++;
        end
    endtask

    task automatic test_branch();
        stim_t s[$]; logic [5:0] e[$]; logic [5:0] got, ex;
        s.push_back(mk(0, 2,1, 5,1, 2,1, 0,0, 1, 0,0)); e.push_back(6'b111000);
        s.push_back(mk(0, 2,1, 5,1, 0,0, 2,1, 1, 0,0)); e.push_back(6'b111000);
        s.push_back(mk(0, 2,1, 5,1, 0,0, 0,0, 1, 0,0)); e.push_back(6'b000100);
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0, 0,0)); e.push_back(6'b000000);
        s.push_back(mk(0, 2,1, 5,1, 7,1, 0,0, 1, 0,0)); e.push_back(6'b000100);
        for (int i = 0; i < s.size(); i++) begin
            @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
            @(negedge clk); got = outs(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) $display("FAIL branch[%0d] got=%b exp=%b", i, got, ex); else passed++;
        end
    endtask

    task automatic test_zero_wait();
        stim_t s[$]; logic [5:0] e[$]; logic [5:0] got, ex;
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0, 1,1)); e.push_back(6'b000000);
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0, 0,1)); e.push_back(6'b000000);
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0, 0,0)); e.push_back(6'b000000);
        for (int i = 0; i < s.size(); i++) begin
            @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
            @(negedge clk); got = outs(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) $display("FAIL zero_wait[%0d] got=%b exp=%b", i, got, ex); else passed++;
        end
    endtask

    task automatic test_timeout();
        stim_t s[$]; logic [5:0] e[$]; logic [5:0] got, ex;
        s.push_back(mk(1, 0,0, 0,0, 0,0, 0,0, 0, 0,0)); e.push_back(6'b000000);
        // short wait leaves the wait counter non-zero before the timeout run
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0, 1,0)); e.push_back(6'b000010);
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0, 1,0)); e.push_back(6'b000010);
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0, 1,1)); e.push_back(6'b000000);
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0, 0,0)); e.push_back(6'b000000);
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0, 1,0)); e.push_back(6'b000010);
        for (int k = 0; k < 4; k++) begin
            s.push_back(mk(0, 1,1, 0,0, 1,1, 0,0, 1, 1,0)); e.push_back(6'b000010);
        end
        for (int k = 0; k < 3; k++) begin
            s.push_back(mk(0, 1,1, 0,0, 1,1, 0,0, 1, 1,1)); e.push_back(6'b000011);
        end
        for (int i = 0; i < s.size(); i++) begin
            @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
            @(negedge clk); got = outs(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) $display("FAIL timeout[%0d] got=%b exp=%b", i, got, ex); else passed++;
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (ld_stall_cnt !== 32'd0 || mem_wait_cnt !== 32'd7)
            $display("FAIL timeout_cnt got=%0d/%0d exp=0/7", ld_stall_cnt, mem_wait_cnt);
        else passed++;
`endif
        s.delete(); e.delete();
        s.push_back(mk(1, 1,1, 0,0, 1,1, 0,0, 1, 1,0)); e.push_back(6'b000000);
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0, 0,0)); e.push_back(6'b000000);
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0, 1,1)); e.push_back(6'b000000);
        s.push_back(mk(0, 1,1, 0,0, 1,1, 0,0, 0, 0,0)); e.push_back(6'b111000);
        for (int i = 0; i < s.size(); i++) begin
            @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
            @(negedge clk); got = outs(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) $display("FAIL err_exit[%0d] got=%b exp=%b", i, got, ex); else passed++;
        end
    endtask

    task automatic test_reset_in_wait();
        stim_t s[$]; logic [5:0] e[$]; logic [5:0] got, ex;
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0, 1,0)); e.push_back(6'b000010);
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0, 1,0)); e.push_back(6'b000010);
        s.push_back(mk(1, 0,0, 0,0, 0,0, 0,0, 0, 1,0)); e.push_back(6'b000000);
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0, 0,0)); e.push_back(6'b000000);
        s.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 1, 0,0)); e.push_back(6'b000100);
        for (int i = 0; i < s.size(); i++) begin
            @(posedge clk); #1; apply(s[i]); exp_q.push_back(e[i]);
            @(negedge clk); got = outs(); ex = exp_q.pop_front(); checks++;
            if (got !== ex) $display("FAIL rst_wait[%0d] got=%b exp=%b", i, got, ex); else passed++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        apply(mk(1, 0,0, 0,0, 0,0, 0,0, 0, 0,0));
        test_reset();
        test_ld_ex();
        test_mem_wait();
        test_no_stall();
        test_branch();
        test_zero_wait();
        test_timeout();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctl.md
HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: max consecutive MEM_WAIT cycles before error (1..255).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports ra_rf / rb_rf, input, 5 bits each: source register addresses of the instruction in RF.
REQ-005 SHALL have ports ra_used_rf / rb_used_rf, input, 1 bit each: the RF instruction reads that operand.
REQ-006 SHALL have port rc_ex, input, 5 bits, and op_ld_ex, input, 1 bit: destination and LD/LDR flag of the EX instruction.
REQ-007 SHALL have port rc_mem, input, 5 bits, and op_ld_mem, input, 1 bit: destination and LD/LDR flag of the MEM instruction.
REQ-008 SHALL have port br_taken_rf, input, 1 bit: BEQ/BNE/JMP in RF redirects the PC.
REQ-009 SHALL have port mem_op_mem, input, 1 bit, and dmem_ack, input, 1 bit: MEM-stage data access pending, and its completion.
REQ-010 SHALL have outputs stall_if and stall_rf, 1 bit each: hold the PC and the IF/RF pipeline register.
REQ-011 SHALL have outputs bubble_ex, 1 bit (inject NOP into EX), and annul_if, 1 bit (replace the IF instruction with NOP).
REQ-012 SHALL have outputs freeze, 1 bit (hold all pipeline registers), and mem_timeout_err, 1 bit (sticky error).

Function
REQ-013 SHALL define ld_hazard = RF operand used, address != 31, and (op_ld_ex && addr==rc_ex || op_ld_mem && addr==rc_mem), for ra or rb.
REQ-014 SHALL have FSM states RUN, MEM_WAIT and ERROR; state SHALL be registered; stall/freeze/annul outputs SHALL be combinational from state and inputs (0-cycle latency).
REQ-015 RUN: freeze = mem_op_mem && !dmem_ack; if freeze=1, next state MEM_WAIT, else RUN.
REQ-016 MEM_WAIT: freeze = !dmem_ack; on dmem_ack, next state RUN, else MEM_WAIT.
REQ-017 wait_cnt (8 bits) SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle without ack; wait_cnt reaching MEM_TIMEOUT without ack SHALL move to ERROR.
REQ-018 ERROR: freeze=1, mem_timeout_err=1, all other outputs 0; exit only by rst.
REQ-019 With freeze=0: ld_hazard=1 SHALL assert stall_if, stall_rf and bubble_ex.
REQ-020 With freeze=0 and ld_hazard=0: br_taken_rf=1 SHALL assert annul_if.
REQ-021 Simultaneous ld_hazard and br_taken_rf SHALL give a stall only; annul_if=0, because the branch operands are invalid.
REQ-022 freeze=1 SHALL force stall_if, stall_rf, bubble_ex and annul_if to 0; freeze has priority.
REQ-023 dmem_ack arriving in the same cycle as mem_op_mem SHALL give zero wait cycles (freeze=0, stays RUN).
REQ-024 A load hazard against LD in EX SHALL stall 2 cycles, and against LD in MEM 1 cycle, absent memory waits.

Reset
REQ-025 rst=1 SHALL set state RUN, wait_cnt 0 and perf counters 0 at the next edge.
REQ-026 While rst=1, all outputs SHALL be 0.
REQ-027 rst asserted in MEM_WAIT or ERROR SHALL return to RUN with no residual freeze after deassertion.

Configuration
REQ-028 With macro HAZARD_PERF_CNT_EN defined, the block SHALL add 32-bit outputs ld_stall_cnt and mem_wait_cnt.
REQ-029 ld_stall_cnt SHALL count cycles with stall_rf=1, and mem_wait_cnt cycles with freeze=1 outside ERROR; both wrap modulo 2^32.
REQ-030 Without HAZARD_PERF_CNT_EN, those ports and registers SHALL be absent and behaviour is otherwise identical.

Structure
REQ-031 The FSM state enum and the register-31 constant SHALL live in the shared CPU package beta_pkg.
REQ-032 No sub-module is required; hazard compare logic SHALL be inline.

Verification
REQ-033 The bench SHALL check: LD R1 in EX, RF ADD reads R1 -> stall_rf=1 for 2 cycles, bubble_ex=1 both cycles, then 0.
REQ-034 The bench SHALL check: LD R31 in EX, RF reads R31 -> no stall.
REQ-035 The bench SHALL check: LD R2 in EX, RF BEQ on R2 with br_taken_rf=1 -> stall_rf=1, annul_if=0; after 2 cycles, annul_if=1 for 1 cycle.
REQ-036 The bench SHALL check: mem_op_mem=1 with ack after 3 cycles -> freeze=1 for exactly 3 cycles, and the stall outputs 0 during them.
REQ-037 The bench SHALL check: MEM_TIMEOUT=4 and no ack -> ERROR reached 4 cycles after MEM_WAIT entry, mem_timeout_err=1 until rst, then RUN.
REQ-038 The bench SHALL check: with HAZARD_PERF_CNT_EN, the scenarios of REQ-033 and REQ-036 -> ld_stall_cnt=2 and mem_wait_cnt=3.
